// File: rtl/indirect_mem_ctrl_pkg.sv
// Shared encodings for the indirect memory controller: request modes and FSM states.
package indirect_mem_ctrl_pkg;
    localparam logic [1:0] MODE_DIR = 2'b00;
    localparam logic [1:0] MODE_IND = 2'b01;
    localparam logic [1:0] MODE_INC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PTR  = 2'b01,
        INC  = 2'b10,
        CLR  = 2'b11
    } state_e;
endpackage

// File: rtl/indirect_mem_ctrl_spram.sv
// Generic single-port RAM, write-enable, registered read (read-first on write).
module spram_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/indirect_mem_ctrl.sv
// Clocked data memory with direct / indirect / indirect post-increment access,
// write echo and an optional zero-fill sweep after reset.
module indirect_mem_ctrl
    import indirect_mem_ctrl_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              clr_busy
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_rd_q, rsp_rd_d;
    logic [DATA_W-1:0] rsp_wdata_q, rsp_wdata_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ptr_q;
    logic              wr_q, inc_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              accept;

    assign req_ready = (state_q == IDLE) && !rst;
    assign clr_busy  = (state_q == CLR) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_wdata_d = rsp_wdata_q;
        ram_we      = 1'b0;
        ram_addr    = req_addr;
        ram_wdata   = req_wdata;
        unique case (state_q)
            IDLE: if (accept) begin
                // The pointer fetch for indirect modes reuses this edge's read.
                if (req_mode == MODE_IND || req_mode == MODE_INC) begin
                    state_d = PTR;
                end else begin
                    ram_we      = req_wr;
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = req_addr;
                    rsp_rd_d    = !req_wr;
                    rsp_wdata_d = req_wdata;
                end
            end
            PTR: begin
                ram_addr    = ram_rdata[ADDR_W-1:0];
                ram_we      = wr_q;
                ram_wdata   = wdata_q;
                rsp_valid_d = 1'b1;
                rsp_addr_d  = ram_rdata[ADDR_W-1:0];
                rsp_rd_d    = !wr_q;
                rsp_wdata_d = wdata_q;
                state_d     = inc_q ? INC : IDLE;
            end
            INC: begin
                // Lands after the data write, so a self-pointer ends as ptr+1.
                ram_addr  = addr_q;
                ram_we    = 1'b1;
                ram_wdata = ptr_q + DATA_W'(1);
                state_d   = IDLE;
            end
            CLR: begin
                ram_addr  = clr_cnt_q;
                ram_we    = 1'b1;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RST) state_q <= CLR;
            else              state_q <= IDLE;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rd_q    <= 1'b0;
            rsp_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_wdata_q <= rsp_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            inc_q   <= (req_mode == MODE_INC);
        end
        if (state_q == PTR) ptr_q <= ram_rdata;
    end

    spram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we && !rst),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Reads come straight off the RAM output register; writes echo their data.
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_valid_q ? (rsp_rd_q ? ram_rdata : rsp_wdata_q) : '0;
endmodule
